// File: rtl/fft_frame_scheduler.sv
// Frame scheduler between the 16-tap sample window and the FFT core: snapshots every HOP samples and streams t15..t0.
// Optional DC_REMOVE_EN inserts a MEAN state and streams each sample minus the frame mean, saturated to 10 bits.
module fft_frame_scheduler #(
    parameter int unsigned HOP     = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             new_t,
    input  logic [255:0]     win_in,
    output logic [9:0]       fft_data,
    output logic             fft_valid,
    input  logic             fft_ready,
    output logic             fft_last,
    input  logic             fft_done,
    output logic             busy,
    output logic [15:0]      frame_cnt,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic             err_timeout
);

    localparam int unsigned TAPS  = 16;
    localparam int unsigned TAP_W = 16;
    localparam int unsigned SMP_W = 10;
    localparam int unsigned HW    = 5;
    localparam int unsigned WW    = $clog2(TIMEOUT + 1);
    localparam logic [HW-1:0] HOP_V = HW'(HOP);

    typedef enum logic [2:0] {IDLE, LOAD, MEAN, SEND, WAIT_DONE} state_t;

    state_t            state;
    logic [HW-1:0]     hop_cnt;
    logic [WW-1:0]     wait_cnt;
    logic [3:0]        idx;
    logic [SMP_W-1:0]  frame [TAPS];
    logic              unused_bits;

    // Only the ten LSBs of each tap carry sample data
    always_comb begin
        unused_bits = 1'b0;
        for (int i = 0; i < TAPS; i++)
            unused_bits = unused_bits ^ (^win_in[i*TAP_W+SMP_W +: TAP_W-SMP_W]);
    end

`ifdef DC_REMOVE_EN
    logic [SMP_W-1:0] mean;
    logic [13:0]      sum_c;

    always_comb begin
        sum_c = 14'd0;
        for (int i = 0; i < TAPS; i++)
            sum_c = sum_c + {{4{frame[i][SMP_W-1]}}, frame[i]};
    end

    function automatic logic [SMP_W-1:0] dc_sat(input logic [SMP_W-1:0] s, input logic [SMP_W-1:0] m);
        logic signed [SMP_W:0] d;
        d = $signed({s[SMP_W-1], s}) - $signed({m[SMP_W-1], m});
        if (d > 11'sd511)
            return 10'h1FF;
        else if (d < -11'sd512)
            return 10'h200;
        else
            return d[SMP_W-1:0];
    endfunction

    function automatic logic [SMP_W-1:0] sample_at(input logic [3:0] i, input logic [SMP_W-1:0] m);
        return dc_sat(frame[i], m);
    endfunction
`else
    function automatic logic [SMP_W-1:0] sample_at(input logic [3:0] i);
        return frame[i];
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            hop_cnt     <= '0;
            wait_cnt    <= '0;
            idx         <= '0;
            fft_data    <= '0;
            fft_valid   <= 1'b0;
            fft_last    <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
            err_timeout <= 1'b0;
            for (int i = 0; i < TAPS; i++) frame[i] <= '0;
`ifdef DC_REMOVE_EN
            mean        <= '0;
`endif
        end else begin
            err_timeout <= 1'b0;

            // Hop counter restarts on frame start, keeping a coincident sample
            if (!enable)
                hop_cnt <= '0;
            else if (state == IDLE && hop_cnt == HOP_V)
                hop_cnt <= new_t ? HW'(1) : '0;
            else if (new_t && hop_cnt != HOP_V)
                hop_cnt <= hop_cnt + HW'(1);

            if (new_t && hop_cnt == HOP_V && state != IDLE && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (enable && hop_cnt == HOP_V) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < TAPS; i++) frame[i] <= win_in[i*TAP_W +: SMP_W];
                    idx <= 4'd15;
`ifdef DC_REMOVE_EN
                    state <= MEAN;
`else
                    state     <= SEND;
                    fft_valid <= 1'b1;
                    fft_last  <= 1'b0;
                    fft_data  <= win_in[15*TAP_W +: SMP_W];
`endif
                end
`ifdef DC_REMOVE_EN
                MEAN: begin
                    mean      <= sum_c[13:4];
                    fft_data  <= sample_at(4'd15, sum_c[13:4]);
                    fft_valid <= 1'b1;
                    fft_last  <= 1'b0;
                    state     <= SEND;
                end
`endif
                SEND: begin
                    if (fft_ready) begin
                        if (idx == 4'd0) begin
                            fft_valid <= 1'b0;
                            fft_last  <= 1'b0;
                            wait_cnt  <= '0;
                            state     <= WAIT_DONE;
                        end else begin
                            idx      <= idx - 4'd1;
                            fft_last <= (idx == 4'd1);
`ifdef DC_REMOVE_EN
                            fft_data <= sample_at(idx - 4'd1, mean);
`else
                            fft_data <= sample_at(idx - 4'd1);
`endif
                        end
                    end
                end
                WAIT_DONE: begin
                    if (fft_done) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler: vector table, hand sequences and randomized frames vs. a frame-level model.
module tb_fft_frame_scheduler;

    localparam int unsigned HOP     = 8;
    localparam int unsigned TIMEOUT = 1024;
    localparam int unsigned CNT_W   = 8;
`ifdef DC_REMOVE_EN
    localparam int LAT = 3;
    localparam bit DC  = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit DC  = 1'b0;
`endif

    typedef logic [9:0] taps_t [16];
    typedef struct {
        logic [9:0] t15;
        logic [9:0] rest;
        logic [9:0] e_first;
        logic [9:0] e_rest;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             new_t;
    logic [255:0]     win_in;
    logic [9:0]       fft_data;
    logic             fft_valid;
    logic             fft_ready;
    logic             fft_last;
    logic             fft_done;
    logic             busy;
    logic [15:0]      frame_cnt;
    logic [CNT_W-1:0] overrun_cnt;
    logic             err_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frames = 0;
    int exp_overrun = 0;

    fft_frame_scheduler #(.HOP(HOP), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .new_t(new_t), .win_in(win_in),
        .fft_data(fft_data), .fft_valid(fft_valid), .fft_ready(fft_ready), .fft_last(fft_last),
        .fft_done(fft_done), .busy(busy), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Upper six bits of each tap get junk so masking is exercised
    task automatic set_window(input taps_t t);
        for (int k = 0; k < 16; k++) win_in[k*16 +: 16] = {6'($urandom), t[k]};
    endtask

    // Frame-level reference: streamed order t15..t0, optionally minus floor(mean), clamped
    task automatic model_stream(input taps_t t, output taps_t r);
        int sum;
        int mean;
        int v;
        sum = 0;
        for (int k = 0; k < 16; k++) sum += int'($signed(t[k]));
        mean = DC ? (sum >>> 4) : 0;
        for (int j = 0; j < 16; j++) begin
            v = int'($signed(t[15-j])) - mean;
            if (v > 511) v = 511;
            if (v < -512) v = -512;
            r[j] = 10'(v);
        end
    endtask

    task automatic trigger;
        for (int p = 0; p < int'(HOP); p++) begin
            repeat ($urandom_range(0, 2)) tick;
            new_t = 1'b1;
            tick;
            new_t = 1'b0;
        end
    endtask

    // mode 0: ready always high, 1: alternating 1,0,..., 2: random
    task automatic collect(input taps_t e, input int mode, input bit scramble);
        int lat;
        int cyc;
        int k;
        bit hold;
        logic [9:0] held;
        logic rdy;
        lat = 0; cyc = 0; k = 0; hold = 1'b0; held = '0;
        while (!fft_valid && lat < 10) begin
            tick;
            lat++;
        end
        check("first_valid_latency", 32'(lat), 32'(LAT));
        if (scramble)
            for (int w = 0; w < 8; w++) win_in[w*32 +: 32] = $urandom;
        while (k < 16 && cyc < 200) begin
            if (hold) check($sformatf("hold_data[%0d]", k), 32'(fft_data), 32'(held));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            fft_ready = rdy;
            hold = 1'b0;
            if (fft_valid && rdy) begin
                check($sformatf("data[%0d]", k), 32'(fft_data), 32'(e[k]));
                check($sformatf("last[%0d]", k), 32'(fft_last), 32'(k == 15));
                k++;
            end else if (fft_valid) begin
                hold = 1'b1;
                held = fft_data;
            end else begin
                check($sformatf("valid_in_send[%0d]", k), 32'(fft_valid), 32'd1);
            end
            tick;
            cyc++;
        end
        fft_ready = 1'b0;
        check("beats", 32'(k), 32'd16);
        if (mode == 0) check("consecutive_cycles", 32'(cyc), 32'd16);
        check("valid_after_last", 32'(fft_valid), 32'd0);
        check("busy_in_wait", 32'(busy), 32'd1);
    endtask

    task automatic give_done;
        fft_done = 1'b1;
        tick;
        fft_done = 1'b0;
        exp_frames++;
        check("frame_cnt", 32'(frame_cnt), 32'(16'(exp_frames)));
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t  vecs [4];
        taps_t tk;
        taps_t ek;
        taps_t t;
        taps_t e;
        int    n;
        bit    extra;

`ifdef DC_REMOVE_EN
        vecs[0] = '{10'd29,  10'd29,  10'd0,   10'd0};
        vecs[1] = '{10'd511, 10'd0,   10'd480, 10'h3E1};
        vecs[2] = '{10'h200, 10'h1FF, 10'h200, 10'd64};
        vecs[3] = '{10'h200, 10'h200, 10'd0,   10'd0};
`else
        vecs[0] = '{10'd100, 10'd7,   10'd100, 10'd7};
        vecs[1] = '{10'h1FF, 10'h200, 10'h1FF, 10'h200};
        vecs[2] = '{10'd0,   10'h3FF, 10'd0,   10'h3FF};
        vecs[3] = '{10'h155, 10'h2AA, 10'h155, 10'h2AA};
`endif
        for (int k = 0; k < 16; k++) begin
            tk[k] = 10'(k);
            ek[k] = 10'(15 - k - (DC ? 7 : 0));
        end

        reset = 1'b0; enable = 1'b0; new_t = 1'b0; win_in = '0;
        fft_ready = 1'b0; fft_done = 1'b0;
        repeat (3) tick;
        check("rst_valid", 32'(fft_valid), 32'd0);
        check("rst_data", 32'(fft_data), 32'd0);
        check("rst_last", 32'(fft_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        reset = 1'b1;
        tick;

        // Samples with enable low must not accumulate
        repeat (10) begin
            new_t = 1'b1; tick; new_t = 1'b0; tick;
        end
        enable = 1'b1;
        repeat (4) tick;
        check("disabled_no_start", 32'(busy), 32'd0);

        fft_done = 1'b1; tick; fft_done = 1'b0;
        check("done_in_idle_ignored", 32'(frame_cnt), 32'd0);

        set_window(tk);
        trigger;
        collect(ek, 0, 1'b0);
        give_done;

        set_window(tk);
        trigger;
        collect(ek, 1, 1'b0);
        give_done;

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 16; k++) t[k] = (k == 15) ? vecs[i].t15 : vecs[i].rest;
            for (int j = 0; j < 16; j++) e[j] = (j == 0) ? vecs[i].e_first : vecs[i].e_rest;
            set_window(t);
            trigger;
            collect(e, 0, 1'b0);
            give_done;
        end

        // Alternating +500/-500 has zero mean
        for (int k = 0; k < 16; k++) t[k] = (k % 2 == 0) ? 10'd500 : 10'h20C;
        for (int j = 0; j < 16; j++) e[j] = t[15-j];
        set_window(t);
        trigger;
        collect(e, 2, 1'b1);
        give_done;

        // Overrun while core holds fft_done, then immediate restart
        set_window(tk);
        trigger;
        collect(ek, 0, 1'b0);
        repeat (10) begin
            new_t = 1'b1; tick; new_t = 1'b0; tick;
        end
        exp_overrun = 2;
        check("overrun_cnt", 32'(overrun_cnt), 32'(exp_overrun));
        give_done;
        collect(ek, 0, 1'b0);
        give_done;

        // Timeout with no fft_done
        set_window(tk);
        trigger;
        collect(ek, 0, 1'b0);
        n = 0;
        while (!err_timeout && n < 1100) begin
            tick;
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("timeout_pulse", 32'(err_timeout), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_frame_cnt", 32'(frame_cnt), 32'(16'(exp_frames)));
        tick;
        check("timeout_pulse_end", 32'(err_timeout), 32'd0);
        extra = 1'b0;
        repeat (20) begin
            tick;
            if (err_timeout) extra = 1'b1;
        end
        check("timeout_single_pulse", 32'(extra), 32'd0);

        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 16; k++)
                t[k] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 10'h1FF : 10'h200)
                                                   : 10'($urandom);
            model_stream(t, e);
            set_window(t);
            trigger;
            collect(e, 2, 1'b1);
            give_done;
        end
        check("overrun_stable", 32'(overrun_cnt), 32'(exp_overrun));

        // Reset on the 5th beat abandons the frame
        set_window(tk);
        trigger;
        n = 0;
        while (!fft_valid && n < 10) begin
            tick;
            n++;
        end
        fft_ready = 1'b1;
        repeat (4) tick;
        check("beat5_valid", 32'(fft_valid), 32'd1);
        check("beat5_data", 32'(fft_data), 32'(ek[4]));
        reset = 1'b0;
        tick;
        check("midrst_valid", 32'(fft_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(fft_data), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_overrun", 32'(overrun_cnt), 32'd0);
        fft_ready = 1'b0;
        repeat (3) tick;
        reset = 1'b1;
        repeat (3) tick;
        check("postrst_valid", 32'(fft_valid), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Sits between the microphone sample shift register (16-tap window, one `new_t` pulse per accepted sample) and the FFT processor.
- Counts incoming samples and, every HOP samples, snapshots the 16-tap window.
- Streams the snapshot to the FFT core, oldest first, over a valid/ready handshake, then waits for the core's completion pulse.
- Reports frames skipped because the core was busy, and FFT timeouts.

Parameters:
- HOP, 8: new samples between frame starts; legal range 1..16.
- TIMEOUT, 1024: maximum clk cycles spent in WAIT_DONE before abort.
- CNT_W, 8: width of the overrun counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  high allows new frames to start.
- new_t  in  1  one-cycle pulse: window updated with a new sample.
- win_in  in  256  window {t15,t14,...,t0}, 16 bits per tap; only bits [9:0] of each tap are used.
- fft_data  out  10  sample to FFT, 10-bit two's complement.
- fft_valid  out  1  fft_data valid.
- fft_ready  in  1  FFT core accepts the sample this cycle.
- fft_last  out  1  high with the 16th sample of a frame.
- fft_done  in  1  one-cycle pulse: FFT finished the frame.
- busy  out  1  high in any state other than IDLE.
- frame_cnt  out  16  frames fully sent and completed; wraps.
- overrun_cnt  out  CNT_W  skipped-hop count; saturates.
- err_timeout  out  1  one-cycle pulse when a frame is aborted by timeout.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, hop_cnt=0, wait_cnt=0, idx=0.
  - fft_data=0, fft_valid=0, fft_last=0, busy=0, frame_cnt=0, overrun_cnt=0, err_timeout=0.
  - Frame buffer cleared to 0.
  - Reset asserted mid-frame abandons the frame immediately; no further fft_valid after the reset edge.
- Hop counter:
  - Increments on new_t and saturates at HOP.
  - Held at 0 while enable==0.
- Overrun: new_t arriving while hop_cnt==HOP and state!=IDLE increments overrun_cnt (saturating at all-ones).
- IDLE:
  - If enable && hop_cnt==HOP, go to LOAD.
  - hop_cnt becomes 0, or 1 if new_t is high in the same cycle.
- LOAD (1 cycle):
  - Latch the ten LSBs of each tap into frame[15:0].
  - Set idx=15; go to SEND.
- SEND:
  - fft_valid=1 and fft_data=frame[idx], streamed t15 first, t0 last.
  - fft_last=1 when idx==0.
  - On fft_valid && fft_ready: idx decrements; after idx==0 is accepted, go to WAIT_DONE.
  - fft_data is held stable while fft_ready==0.
- WAIT_DONE:
  - wait_cnt increments each cycle.
  - On fft_done: frame_cnt++, go to IDLE.
  - If wait_cnt reaches TIMEOUT-1 without fft_done: pulse err_timeout, go to IDLE; frame_cnt unchanged.
  - fft_done arriving outside WAIT_DONE is ignored.
- Latency: snapshot taken the cycle after the triggering state; first fft_valid 2 cycles after IDLE sees hop_cnt==HOP.
- Window changes during SEND do not affect the frame in flight.
- enable dropping mid-frame does not abort the frame; it only blocks the next start.

Optional Feature:
- DC_REMOVE_EN defined:
  - An extra MEAN state (1 cycle) follows LOAD.
  - MEAN sums the 16 sign-extended samples into 14 bits and computes mean = sum>>>4 (arithmetic shift).
  - Each streamed sample is frame[idx]-mean, saturated to the 10-bit range [-512, 511].
  - First fft_valid moves to 3 cycles after the trigger.
- DC_REMOVE_EN undefined: no MEAN state; samples are streamed unmodified.

Test Plan:
- Reset, enable=1, 8 new_t pulses with taps t_k=k → LOAD; fft_data sequence 15,14,...,0 with fft_last only on 0; fft_ready=1 gives 16 consecutive valid cycles.
- fft_ready toggled 1,0,1,0 during SEND → fft_data held during ready-low cycles; all 16 samples delivered in order with no duplicates.
- fft_done withheld while 10 further new_t pulses arrive → overrun_cnt=2 (hop_cnt saturates at 8 after 8 pulses); fft_done then gives frame_cnt=1 and an immediate new frame.
- fft_done never returned, TIMEOUT=1024 → err_timeout pulses exactly once, 1024 cycles after entering WAIT_DONE; busy drops; frame_cnt=0.
- reset=0 on the 5th SEND beat → next cycle fft_valid=0, busy=0, all counters 0.
- DC_REMOVE_EN, all taps 10'd29 → all fft_data=0; taps alternating 500/-500 → outputs 500/-500 (mean 0); taps t15=511, others 0 → first output 480, the rest -31.
